// File: rtl/keccak_theta.sv
// Keccak-f[1600] theta step, lane-serial in and out.
// Loads 25 lanes (x fastest) into a buffer while accumulating column parities C[x],
// spends one cycle registering D[x] = C[x-1] ^ rol(C[x+1], 1), then streams
// buf[k] ^ D[k%5] back out in the same lane order.
// Optional build macro: KECCAK_THETA_COLPAR_EN adds o_colpar = {C[4],...,C[0]}.
module keccak_theta #(
  parameter int unsigned BW_A   = 64,
  parameter int unsigned N_LANE = 25,
  parameter int unsigned BW_IDX = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BW_A-1:0]   i_lane,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [BW_A-1:0]   o_lane,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
`ifdef KECCAK_THETA_COLPAR_EN
  ,
  output logic [5*BW_A-1:0] o_colpar
`endif
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  localparam logic [BW_IDX-1:0] LAST_IDX = BW_IDX'(N_LANE - 1);
  localparam logic [2:0]        LAST_X   = 3'd4;

  logic [1:0]        state;
  logic [BW_IDX-1:0] cnt;
  logic [2:0]        x_cnt;
  logic [2:0]        y_cnt;
  logic [BW_A-1:0]   lane_buf [N_LANE];
  logic [BW_A-1:0]   col_par  [5];
  logic [BW_A-1:0]   theta_d  [5];
  logic              in_hs;
  logic              out_hs;

  function automatic logic [BW_A-1:0] rol1(input logic [BW_A-1:0] v);
    return {v[BW_A-2:0], v[BW_A-1]};
  endfunction

  // Handshake flags and state-decoded outputs; o_lane muxes straight from the buffer.
  always_comb begin
    o_ready = (state == ST_LOAD);
    o_valid = (state == ST_EMIT);
    o_busy  = (state != ST_LOAD);
    in_hs   = i_valid & o_ready;
    out_hs  = o_valid & i_ready;
    o_lane  = o_valid ? (lane_buf[cnt] ^ theta_d[x_cnt]) : '0;
  end

  // FSM and lane/column/row counters; counters wrap only on a state transition.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_LOAD;
      cnt   <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_hs) begin
            if (cnt == LAST_IDX) begin
              state <= ST_CALC;
              cnt   <= '0;
              x_cnt <= '0;
              y_cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              if (x_cnt == LAST_X) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 1'b1;
              end else begin
                x_cnt <= x_cnt + 1'b1;
              end
            end
          end
        end
        ST_CALC: state <= ST_EMIT;
        ST_EMIT: begin
          if (out_hs) begin
            if (cnt == LAST_IDX) begin
              state <= ST_LOAD;
              cnt   <= '0;
              x_cnt <= '0;
              y_cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              if (x_cnt == LAST_X) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 1'b1;
              end else begin
                x_cnt <= x_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Column parity accumulation (row 0 overwrites, so no clear cycle) and D registration.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 5; i++) begin
        col_par[i] <= '0;
        theta_d[i] <= '0;
      end
    end else begin
      if (in_hs) begin
        col_par[x_cnt] <= (y_cnt == 3'd0) ? i_lane : (col_par[x_cnt] ^ i_lane);
      end
      if (state == ST_CALC) begin
        theta_d[0] <= col_par[4] ^ rol1(col_par[1]);
        theta_d[1] <= col_par[0] ^ rol1(col_par[2]);
        theta_d[2] <= col_par[1] ^ rol1(col_par[3]);
        theta_d[3] <= col_par[2] ^ rol1(col_par[4]);
        theta_d[4] <= col_par[3] ^ rol1(col_par[0]);
      end
      if (out_hs && (cnt == LAST_IDX)) begin
        for (int unsigned i = 0; i < 5; i++) begin
          col_par[i] <= '0;
        end
      end
    end
  end

  // Lane buffer; contents are don't-care after reset, so no reset here.
  always_ff @(posedge i_clk) begin
    if (in_hs) begin
      lane_buf[cnt] <= i_lane;
    end
  end

`ifdef KECCAK_THETA_COLPAR_EN
  assign o_colpar = {col_par[4], col_par[3], col_par[2], col_par[1], col_par[0]};
`endif

endmodule

// File: tb/tb_keccak_theta.sv
// Scoreboard bench for keccak_theta: drivers push hand-derived expected lanes,
// a negedge monitor pops and compares on each output handshake.
module tb_keccak_theta;

  localparam logic [63:0] MSB = 64'h8000000000000000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] i_lane = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [63:0] o_lane;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_busy;
`ifdef KECCAK_THETA_COLPAR_EN
  logic [319:0] o_colpar;
`endif

  int tests = 0;
  int fails = 0;
  logic [63:0] sb [$];
  logic [63:0] vec   [25];
  logic [63:0] exp_v [25];
  logic        stall_pending = 1'b0;
  logic [63:0] stall_lane = '0;
  logic [63:0] exp_lane;

  keccak_theta #(.BW_A(64), .N_LANE(25), .BW_IDX(5)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_lane  (i_lane),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_lane  (o_lane),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_busy  (o_busy)
`ifdef KECCAK_THETA_COLPAR_EN
    ,
    .o_colpar(o_colpar)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: compare on each output handshake, and hold-stability while stalled.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (stall_pending) begin
        tests++;
        if (o_lane !== stall_lane) begin
          fails++;
          $display("FAIL stall_stable: got %h expected %h", o_lane, stall_lane);
        end
      end
      if (i_ready) begin
        stall_pending = 1'b0;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_lane: got %h expected none", o_lane);
        end else begin
          exp_lane = sb.pop_front();
          if (o_lane !== exp_lane) begin
            fails++;
            $display("FAIL lane: got %h expected %h", o_lane, exp_lane);
          end
        end
      end else begin
        stall_pending = 1'b1;
        stall_lane    = o_lane;
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  task automatic clear_vec();
    for (int k = 0; k < 25; k++) begin
      vec[k]   = '0;
      exp_v[k] = '0;
    end
  endtask

  // Lane 0 = 1: D[1] = 1, D[4] = 2.
  task automatic add_lane0();
    vec[0]   ^= 64'h1;
    exp_v[0] ^= 64'h1;
    for (int y = 0; y < 5; y++) begin
      exp_v[5*y+1] ^= 64'h1;
      exp_v[5*y+4] ^= 64'h2;
    end
  endtask

  // Lane 2 = MSB: D[3] = MSB, D[1] = rol(MSB) = 1.
  task automatic add_lane2();
    vec[2]   ^= MSB;
    exp_v[2] ^= MSB;
    for (int y = 0; y < 5; y++) begin
      exp_v[5*y+1] ^= 64'h1;
      exp_v[5*y+3] ^= MSB;
    end
  endtask

  task automatic push_exp();
    for (int k = 0; k < 25; k++) sb.push_back(exp_v[k]);
  endtask

  task automatic wait_ready();
    int cyc = 0;
    @(negedge i_clk);
    while (!o_ready && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    if (!o_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got o_ready=0 expected 1");
    end
  endtask

  task automatic load_lanes(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      i_lane  = vec[k];
      i_valid = 1'b1;
      wait_ready();
      @(posedge i_clk); #1;
      if (gap > 0 && k < n - 1) begin
        i_valid = 1'b0;
        i_lane  = 64'hDEAD_BEEF_0BAD_F00D;
        repeat (gap) begin @(posedge i_clk); #1; end
      end
    end
    i_valid = 1'b0;
  endtask

  // Drive downstream ready until only `left` expected lanes remain queued.
  task automatic drain(input int left, input int mode, input bit junk);
    int cyc = 0;
    while (sb.size() > left && cyc < 600) begin
      i_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (junk) begin
        i_valid = 1'b1;
        i_lane  = {$urandom, $urandom};
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    if (sb.size() > left) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d queued expected %0d", sb.size(), left);
    end
  endtask

  task automatic run_full(input int mode, input int gap, input bit junk);
    push_exp();
    load_lanes(25, gap);
    if (junk) begin
      i_valid = 1'b1;
      i_lane  = {$urandom, $urandom};
    end
    check("calc_valid", {63'd0, o_valid}, 64'd0);
    check("calc_ready", {63'd0, o_ready}, 64'd0);
    check("calc_busy",  {63'd0, o_busy},  64'd1);
    @(posedge i_clk); #1;
    check("first_valid", {63'd0, o_valid}, 64'd1);
    check("emit_ready",  {63'd0, o_ready}, 64'd0);
    drain(0, mode, junk);
    check("done_valid", {63'd0, o_valid}, 64'd0);
    check("done_ready", {63'd0, o_ready}, 64'd1);
    check("done_busy",  {63'd0, o_busy},  64'd0);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_rst   = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    sb.delete();
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_busy",  {63'd0, o_busy},  64'd0);
    check("rst_lane",  o_lane, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("init_valid", {63'd0, o_valid}, 64'd0);
    check("init_ready", {63'd0, o_ready}, 64'd1);
    check("init_busy",  {63'd0, o_busy},  64'd0);
    check("init_lane",  o_lane, 64'd0);
`ifdef KECCAK_THETA_COLPAR_EN
    tests++;
    if (o_colpar !== '0) begin
      fails++;
      $display("FAIL init_colpar: got %h expected 0", o_colpar);
    end
`endif

    // All-zero state.
    clear_vec();
    run_full(0, 0, 1'b0);

    // Single bit in lane 0.
    clear_vec();
    add_lane0();
    run_full(0, 0, 1'b0);

    // MSB in lane 2 (rotate wrap), with 1,0,0,1 backpressure.
    clear_vec();
    add_lane2();
    run_full(1, 0, 1'b0);

    // Both patterns, 3-cycle input gaps, junk i_valid during CALC/EMIT, backpressure.
    clear_vec();
    add_lane0();
    add_lane2();
    run_full(1, 3, 1'b1);

    // All ones: every C is all ones, D is zero.
    clear_vec();
    for (int k = 0; k < 25; k++) begin
      vec[k]   = '1;
      exp_v[k] = '1;
    end
    run_full(0, 0, 1'b0);

    // Same column twice cancels: C all zero, output equals input.
    clear_vec();
    vec[0]   = 64'h1;
    vec[5]   = 64'h1;
    exp_v[0] = 64'h1;
    exp_v[5] = 64'h1;
    run_full(0, 0, 1'b0);

    // Reset after 10 lanes loaded, then a fresh state.
    clear_vec();
    for (int k = 0; k < 25; k++) vec[k] = 64'h0123_4567_89AB_CDEF ^ 64'(k);
    load_lanes(10, 0);
    do_reset();
    clear_vec();
    add_lane0();
    run_full(0, 0, 1'b0);

    // Reset after 7 lanes emitted, then a fresh state.
    clear_vec();
    add_lane2();
    push_exp();
    load_lanes(25, 0);
    @(posedge i_clk); #1;
    drain(18, 0, 1'b0);
    do_reset();
    clear_vec();
    add_lane0();
    add_lane2();
    run_full(1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
